// File: rtl/ringctr_pkg.sv
// Shared definitions for the ring counter and its receive-side monitor:
// state encoding, default ring length and the rotate / one-hot helpers.
package ringctr_pkg;

    localparam int RING_WIDTH_DEFAULT = 4;
    localparam int RING_WIDTH_MAX     = 16;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        S_SEARCH = ST_SEARCH,
        S_TRACK  = ST_TRACK,
        S_LOCKED = ST_LOCKED
    } mon_state_t;

    // Rotate the low w bits of v left by one; bits at or above w stay 0.
    function automatic logic [RING_WIDTH_MAX-1:0] rotl1(
        input logic [RING_WIDTH_MAX-1:0] v,
        input int                        w
    );
        logic [RING_WIDTH_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < RING_WIDTH_MAX; i++) begin
            if (i < w) begin
                if (i == w - 1) r[0] = v[i];
                else            r[(i + 1) % RING_WIDTH_MAX] = v[i];
            end
        end
        return r;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [RING_WIDTH_MAX-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder. Each set bit ORs its own index into the
// result, so there is no priority chain; the output is only meaningful
// when the input is genuinely one-hot.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_i,
    output logic [IW-1:0]    idx_o
);

    // OR together the indices of all set bits.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_i[i]) idx_o = idx_o | IW'(i);
        end
    end

endmodule

// File: rtl/ring_monitor.sv
// Receive-side checker for the ring counter. Tracks the one-hot state,
// acquires lock after two correctly rotated samples, flags one-hot and
// sequence errors, counts revolutions and errors.
//
// Handshake: q_in is consumed on every rising clk edge where valid_in=1;
// there is no back-pressure, so the monitor accepts a sample every cycle.
module ring_monitor
    import ringctr_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEFAULT,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             valid_in,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             onehot_err,
    output logic             seq_err,
    output logic             wrap,
    output logic [7:0]       rev_count,
    output logic [7:0]       err_count,
    output logic [1:0]       dbg_state
);

    mon_state_t                state_q, state_d;
    logic [WIDTH-1:0]          prev_q, prev_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      idx_valid_q, idx_valid_d;
    logic                      onehot_err_q, onehot_err_d;
    logic                      seq_err_q, seq_err_d;
    logic                      wrap_q, wrap_d;
    logic [7:0]                rev_q, rev_d;
    logic [7:0]                err_q, err_d;

    logic [RING_WIDTH_MAX-1:0] samp_ext;
    logic [RING_WIDTH_MAX-1:0] succ_ext;
    logic                      samp_onehot;
    logic                      samp_is_succ;
    logic [IW-1:0]             samp_idx;
    logic [7:0]                err_inc;

    assign samp_ext     = RING_WIDTH_MAX'(q_in);
    assign succ_ext     = rotl1(RING_WIDTH_MAX'(prev_q), WIDTH);
    assign samp_onehot  = is_onehot(samp_ext);
    // Upper bits of both operands are zero, so a full-width compare is exact.
    assign samp_is_succ = (samp_ext == succ_ext);
    assign err_inc      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_enc (
        .onehot_i (q_in),
        .idx_o    (samp_idx)
    );

    // Next-state, register and pulse decode for one sample.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        idx_d        = idx_q;
        rev_d        = rev_q;
        err_d        = err_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        wrap_d       = 1'b0;

        if (valid_in) begin
            if (!samp_onehot) begin
                // Bad sample: drop lock, keep last good position.
                state_d      = S_SEARCH;
                onehot_err_d = 1'b1;
                err_d        = err_inc;
            end else begin
                prev_d      = q_in;
                idx_d       = samp_idx;
                idx_valid_d = 1'b1;
                case (state_q)
                    S_SEARCH: state_d = S_TRACK;
                    S_TRACK:  state_d = samp_is_succ ? S_LOCKED : S_TRACK;
                    S_LOCKED: begin
                        if (samp_is_succ) begin
                            state_d = S_LOCKED;
                            if (prev_q[WIDTH-1]) begin
                                wrap_d = 1'b1;
                                rev_d  = rev_q + 8'd1;
                            end
                        end else begin
                            state_d   = S_TRACK;
                            seq_err_d = 1'b1;
                            err_d     = err_inc;
                        end
                    end
                    default: state_d = S_SEARCH;
                endcase
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_SEARCH;
            prev_q       <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_q       <= 1'b0;
            rev_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            wrap_q       <= wrap_d;
            rev_q        <= rev_d;
            err_q        <= err_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign locked     = (state_q == S_LOCKED);
    assign onehot_err = onehot_err_q;
    assign seq_err    = seq_err_q;
    assign wrap       = wrap_q;
    assign rev_count  = rev_q;
    assign err_count  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor (WIDTH=4): directed scenarios plus random
// stimulus, checked against a position-based reference model.
module tb_ring_monitor;

    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          reset;
    logic [W-1:0]  q_in;
    logic          valid_in;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          locked;
    logic          onehot_err;
    logic          seq_err;
    logic          wrap;
    logic [7:0]    rev_count;
    logic [7:0]    err_count;
    logic [1:0]    dbg_state;

    int total;
    int bad;

    // Reference model: positions as integers, -1 means "no usable previous sample".
    int m_last;
    bit m_locked;
    int m_idx;
    int m_rev;
    int m_err;
    bit m_iv, m_oh, m_seq, m_wrap;

    ring_monitor #(.WIDTH(W), .IW(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .valid_in   (valid_in),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .wrap       (wrap),
        .rev_count  (rev_count),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pos_of(input logic [W-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = -1; m_locked = 0; m_idx = 0; m_rev = 0; m_err = 0;
        m_iv = 0; m_oh = 0; m_seq = 0; m_wrap = 0;
    endtask

    task automatic model_step(input logic [W-1:0] v, input logic vld);
        int  p;
        bit  succ;
        m_iv = 0; m_oh = 0; m_seq = 0; m_wrap = 0;
        if (!vld) return;
        p = pos_of(v);
        if (p < 0) begin
            m_oh = 1;
            if (m_err < 255) m_err++;
            m_locked = 0;
            m_last = -1;
        end else begin
            succ = (m_last >= 0) && (p == (m_last + 1) % W);
            m_idx = p;
            m_iv = 1;
            if (m_locked && !succ) begin
                m_seq = 1;
                if (m_err < 255) m_err++;
            end
            if (m_locked && succ && m_last == W - 1) begin
                m_wrap = 1;
                m_rev = (m_rev + 1) % 256;
            end
            m_locked = succ;
            m_last = p;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":idx"},        int'(idx),        m_idx);
        chk({where, ":idx_valid"},  int'(idx_valid),  int'(m_iv));
        chk({where, ":locked"},     int'(locked),     int'(m_locked));
        chk({where, ":onehot_err"}, int'(onehot_err), int'(m_oh));
        chk({where, ":seq_err"},    int'(seq_err),    int'(m_seq));
        chk({where, ":wrap"},       int'(wrap),       int'(m_wrap));
        chk({where, ":rev_count"},  int'(rev_count),  m_rev);
        chk({where, ":err_count"},  int'(err_count),  m_err);
    endtask

    // Driver: present a sample at negedge, check outputs just after posedge.
    task automatic step(input string where, input logic [W-1:0] v, input logic vld);
        @(negedge clk);
        q_in = v;
        valid_in = vld;
        @(posedge clk);
        #1;
        model_step(v, vld);
        check_all(where);
    endtask

    // Reset between clock edges and confirm it takes effect without a clock.
    task automatic async_reset(input string where);
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(where);
        chk({where, ":dbg_state"}, int'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic         vld;
        int           r;
        total = 0;
        bad   = 0;
        q_in = '0;
        valid_in = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset:dbg_state", int'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;

        // Clean stream: lock after sample 2, wrap after sample 5.
        step("s1", 4'b0001, 1'b1);
        chk("s1:not_locked_yet", int'(locked), 0);
        step("s2", 4'b0010, 1'b1);
        chk("s2:locked", int'(locked), 1);
        chk("s2:dbg_state", int'(dbg_state), 2);
        step("s3", 4'b0100, 1'b1);
        step("s4", 4'b1000, 1'b1);
        step("s5", 4'b0001, 1'b1);
        chk("s5:wrap", int'(wrap), 1);
        chk("s5:rev", int'(rev_count), 1);
        step("s6", 4'b0010, 1'b1);
        chk("s6:idx", int'(idx), 1);
        chk("s6:err", int'(err_count), 0);

        // Non-one-hot injection, then relock.
        step("oh", 4'b0110, 1'b1);
        chk("oh:pulse", int'(onehot_err), 1);
        chk("oh:idx_hold", int'(idx), 1);
        chk("oh:err", int'(err_count), 1);
        step("rl1", 4'b0100, 1'b1);
        chk("rl1:locked", int'(locked), 0);
        step("rl2", 4'b1000, 1'b1);
        chk("rl2:locked", int'(locked), 1);

        // Sequence error from LOCKED at 0010, then recovery without wrap.
        step("sq0", 4'b0001, 1'b1);
        step("sq1", 4'b0010, 1'b1);
        step("sq2", 4'b1000, 1'b1);
        chk("sq2:seq_err", int'(seq_err), 1);
        chk("sq2:idx", int'(idx), 3);
        chk("sq2:track", int'(dbg_state), 1);
        step("sq3", 4'b0001, 1'b1);
        chk("sq3:locked", int'(locked), 1);
        chk("sq3:no_wrap", int'(wrap), 0);

        // Stalled sample in LOCKED is a sequence error.
        step("st0", 4'b0010, 1'b1);
        step("st1", 4'b0010, 1'b1);
        chk("st1:seq_err", int'(seq_err), 1);

        // Valid toggling with garbage on idle cycles.
        for (int i = 0; i < 12; i++) begin
            step("gap_v", W'(1) << ((i + 3) % W), 1'b1);
            step("gap_i", 4'b0000, 1'b0);
        end

        // Random stimulus, mostly well-formed.
        for (int i = 0; i < 400; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7 && m_last >= 0) v = W'(1) << ((m_last + 1) % W);
            else if (r < 9)           v = W'(1) << $urandom_range(0, W - 1);
            else                      v = W'($urandom_range(0, 15));
            step("rnd", v, vld);
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            step("sat_v", 4'b0000, 1'b1);
            step("sat_i", 4'b0101, 1'b0);
        end
        chk("sat:err", int'(err_count), 255);

        // Revolution counter wraps modulo 256.
        async_reset("rst1");
        for (int i = 0; i <= 260 * W; i++) begin
            step("rev", W'(1) << (i % W), 1'b1);
        end
        chk("rev:count", int'(rev_count), 4);
        chk("rev:locked", int'(locked), 1);

        // Async reset while LOCKED, then two samples needed to relock.
        async_reset("rst2");
        step("ar1", 4'b0100, 1'b1);
        chk("ar1:locked", int'(locked), 0);
        step("ar2", 4'b1000, 1'b1);
        chk("ar2:locked", int'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
